// File: rtl/uart_pkg.sv
// Shared UART types and helpers: TX scheduler FSM states and the ID tag byte format.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START_TAG,
    S_WAIT_TAG,
    S_START_DATA,
    S_WAIT_DATA,
    S_DONE
  } sched_state_t;

  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  function automatic logic [7:0] tag_byte(input logic [3:0] id);
    return {TAG_NIBBLE, id};
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first requester strictly after last_grant wins,
// searching upwards and wrapping modulo N_REQ.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_idx
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IW:0]        start_pos;
  logic [IW:0]        pick_rot;
  logic [IW:0]        pick_sum;

  // Rotate so the search origin sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    start_pos = (last_grant == IW'(N_REQ - 1)) ? '0
              : (IW + 1)'(last_grant) + (IW + 1)'(1);
    req_dbl   = {req, req};
    req_rot   = N_REQ'(req_dbl >> start_pos);
    pick_rot  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) pick_rot = (IW + 1)'(i);
    end
    pick_sum = pick_rot + start_pos;
    if (pick_sum >= (IW + 1)'(N_REQ)) pick_sum = pick_sum - (IW + 1)'(N_REQ);
    grant_idx   = pick_sum[IW-1:0];
    grant_valid = |req;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter among N_REQ clients, with optional ID tag
// byte ahead of each data byte and a watchdog on the UART done handshake.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TAG_EN         = 0,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            ack,
  output logic [N_REQ-1:0]            err,
  output logic                        busy,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        start,
  output logic [DATA_WIDTH-1:0]       tx_data_in,
  input  logic                        done_tx,
  input  logic                        tx_active
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  sched_state_t          state;
  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         pick_idx;
  logic                  pick_valid;
  logic [DATA_WIDTH-1:0] data_q;
  logic [TW-1:0]         timer;
  logic                  done_tx_q;
  logic                  done_edge;
  logic                  timed_out;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req         (req),
    .last_grant  (last_grant),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  // A done_tx level left over from an earlier frame must not complete the current one.
  assign done_edge = done_tx & ~done_tx_q;
  assign timed_out = (timer + TW'(1)) == TW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      ack        <= '0;
      err        <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= '0;
      tx_data_in <= '0;
      last_grant <= IW'(N_REQ - 1);
      timer      <= '0;
      done_tx_q  <= 1'b0;
    end else begin
      ack       <= '0;
      err       <= '0;
      start     <= 1'b0;
      done_tx_q <= done_tx;
      case (state)
        S_IDLE: begin
          if (pick_valid && !tx_active) begin
            grant_id   <= pick_idx;
            last_grant <= pick_idx;
            data_q     <= req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            busy       <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          start <= 1'b1;
          if (TAG_EN != 0) begin
            tx_data_in <= DATA_WIDTH'(tag_byte(4'(grant_id)));
            state      <= S_START_TAG;
          end else begin
            tx_data_in <= data_q;
            state      <= S_START_DATA;
          end
        end
        S_START_TAG: begin
          timer <= '0;
          state <= S_WAIT_TAG;
        end
        S_START_DATA: begin
          timer <= '0;
          state <= S_WAIT_DATA;
        end
        S_WAIT_TAG, S_WAIT_DATA: begin
          timer <= timer + TW'(1);
          if (done_edge) begin
            if (state == S_WAIT_TAG) begin
              tx_data_in <= data_q;
              start      <= 1'b1;
              state      <= S_START_DATA;
            end else begin
              ack[grant_id] <= 1'b1;
              state         <= S_DONE;
            end
          end else if (timed_out) begin
            err[grant_id] <= 1'b1;
            busy          <= 1'b0;
            state         <= S_IDLE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench: an untagged scheduler (a) and a tagged one (b), each with a simple UART model.
module tb_uart_tx_scheduler;

  logic        clk;
  logic        rst;
  logic        act;
  int          cyc;

  logic [3:0]  req_a, ack_a, err_a;
  logic [31:0] data_a;
  logic        busy_a, start_a, done_a;
  logic [1:0]  gid_a;
  logic [7:0]  tx_a;
  logic        auto_a, done_auto_a, done_man_a;

  logic [3:0]  req_b, ack_b, err_b;
  logic [31:0] data_b;
  logic        busy_b, start_b, done_b;
  logic [1:0]  gid_b;
  logic [7:0]  tx_b;

  int n_checks;
  int n_errors;

  logic [7:0] tx_log_a[$];
  logic [1:0] gid_log_a[$];
  logic [3:0] ack_log_a[$];
  logic [3:0] err_log_a[$];
  logic [7:0] tx_log_b[$];
  logic [3:0] ack_log_b[$];
  int start_cyc_a, ack_cyc_a, err_cyc_a, done_cyc_a;
  int n_err_b;

  assign done_a = done_auto_a | done_man_a;

  uart_tx_scheduler #(.N_REQ(4), .DATA_WIDTH(8), .TAG_EN(0), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .req(req_a), .req_data(data_a), .ack(ack_a), .err(err_a),
    .busy(busy_a), .grant_id(gid_a), .start(start_a), .tx_data_in(tx_a),
    .done_tx(done_a), .tx_active(act)
  );

  uart_tx_scheduler #(.N_REQ(4), .DATA_WIDTH(8), .TAG_EN(1), .TIMEOUT_CYCLES(100)) dut_tag (
    .clk(clk), .rst(rst), .req(req_b), .req_data(data_b), .ack(ack_b), .err(err_b),
    .busy(busy_b), .grant_id(gid_b), .start(start_b), .tx_data_in(tx_b),
    .done_tx(done_b), .tx_active(act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // UART model a: done drops on start, rises 3 cycles later and stays high until the next start.
  initial begin
    done_auto_a = 1'b0;
    done_cyc_a  = 0;
    forever begin : resp_a
      int cnt;
      cnt = 0;
      forever begin
        @(negedge clk);
        if (!auto_a) begin
          done_auto_a = 1'b0;
          cnt = 0;
        end else if (start_a) begin
          done_auto_a = 1'b0;
          cnt = 3;
        end else if (cnt > 0) begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            done_auto_a = 1'b1;
            done_cyc_a  = cyc;
          end
        end
      end
    end
  end

  initial begin
    done_b = 1'b0;
    forever begin : resp_b
      int cnt;
      cnt = 0;
      forever begin
        @(negedge clk);
        if (start_b) begin
          done_b = 1'b0;
          cnt = 3;
        end else if (cnt > 0) begin
          cnt = cnt - 1;
          if (cnt == 0) done_b = 1'b1;
        end
      end
    end
  end

  initial begin
    n_err_b = 0;
    forever begin
      @(negedge clk);
      if (start_a) begin
        tx_log_a.push_back(tx_a);
        gid_log_a.push_back(gid_a);
        start_cyc_a = cyc;
      end
      if (ack_a != 4'd0) begin
        ack_log_a.push_back(ack_a);
        ack_cyc_a = cyc;
      end
      if (err_a != 4'd0) begin
        err_log_a.push_back(err_a);
        err_cyc_a = cyc;
      end
      if (start_b) tx_log_b.push_back(tx_b);
      if (ack_b != 4'd0) ack_log_b.push_back(ack_b);
      if (err_b != 4'd0) n_err_b = n_err_b + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return ack_a != 4'd0;
      1:       return err_a != 4'd0;
      2:       return start_a;
      default: return ack_b != 4'd0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int bound, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (!cond(which) && n < bound);
    check_eq(tag, 32'(cond(which)), 32'd1);
    #1;
  endtask

  initial begin
    int bs, bk, be, req_cyc;
    n_checks = 0;
    n_errors = 0;
    act = 1'b0;
    rst = 1'b0;
    req_a = '0; data_a = '0; auto_a = 1'b1; done_man_a = 1'b0;
    req_b = '0; data_b = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_busy",  32'(busy_a),  32'd0);
    check_eq("rst_start", 32'(start_a), 32'd0);
    check_eq("rst_ack",   32'(ack_a),   32'd0);
    check_eq("rst_err",   32'(err_a),   32'd0);
    check_eq("rst_gid",   32'(gid_a),   32'd0);
    check_eq("rst_tx",    32'(tx_a),    32'd0);
    check_eq("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single requester
    bs = tx_log_a.size(); bk = ack_log_a.size(); be = err_log_a.size();
    data_a = 32'h0000_00A5;
    req_a  = 4'b0001;
    req_cyc = cyc;
    wait_for(0, 100, "t1_wait_ack");
    req_a = '0;
    check_eq("t1_ack",       32'(ack_log_a[bk]),   32'h1);
    check_eq("t1_tx",        32'(tx_log_a[bs]),    32'hA5);
    check_eq("t1_start_lat", 32'(start_cyc_a - req_cyc), 32'd2);
    check_eq("t1_ack_lat",   32'(ack_cyc_a - done_cyc_a), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("t1_nstart", 32'(tx_log_a.size() - bs),  32'd1);
    check_eq("t1_nack",   32'(ack_log_a.size() - bk), 32'd1);
    check_eq("t1_nerr",   32'(err_log_a.size() - be), 32'd0);
    check_eq("t1_busy",   32'(busy_a), 32'd0);

    // Contention from reset: 0,1,2,3,0
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bs = tx_log_a.size(); bk = ack_log_a.size();
    data_a = 32'h4433_2211;
    req_a  = 4'b1111;
    for (int i = 0; i < 5; i++) wait_for(0, 100, "t2_wait_ack");
    req_a = '0;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t2_ack%0d", i), 32'(ack_log_a[bk+i]), 32'(4'b0001 << (i % 4)));
      check_eq($sformatf("t2_gid%0d", i), 32'(gid_log_a[bs+i]), 32'(i % 4));
      check_eq($sformatf("t2_tx%0d", i),  32'(tx_log_a[bs+i]),  32'((i % 4 + 1) * 8'h11));
    end

    // last_grant=1 then req=1011 -> 3, 0, 1
    repeat (2) @(negedge clk);
    req_a = 4'b0010;
    wait_for(0, 100, "t2b_wait_ack1");
    req_a = '0;
    repeat (2) @(negedge clk);
    bs = gid_log_a.size(); bk = ack_log_a.size();
    req_a = 4'b1011;
    for (int i = 0; i < 3; i++) wait_for(0, 100, "t2b_wait_ack");
    req_a = '0;
    check_eq("t2b_gid0", 32'(gid_log_a[bs]),   32'd3);
    check_eq("t2b_gid1", 32'(gid_log_a[bs+1]), 32'd0);
    check_eq("t2b_gid2", 32'(gid_log_a[bs+2]), 32'd1);
    check_eq("t2b_ack0", 32'(ack_log_a[bk]),   32'b1000);
    check_eq("t2b_tx0",  32'(tx_log_a[bs]),    32'h44);
    check_eq("t2b_tx2",  32'(tx_log_a[bs+2]),  32'h22);

    // Tagged transfer, requester 2
    data_b = 32'h003C_0000;
    req_b  = 4'b0100;
    wait_for(3, 200, "t3_wait_ack");
    req_b = '0;
    check_eq("t3_gid",    32'(gid_b), 32'd2);
    check_eq("t3_nstart", 32'(tx_log_b.size()), 32'd2);
    check_eq("t3_tag",    32'(tx_log_b[0]), 32'hA2);
    check_eq("t3_data",   32'(tx_log_b[1]), 32'h3C);
    repeat (3) @(negedge clk);
    check_eq("t3_nack",   32'(ack_log_b.size()), 32'd1);
    check_eq("t3_ack",    32'(ack_log_b[0]), 32'b0100);
    check_eq("t3_nerr",   32'(n_err_b), 32'd0);

    // Timeout with done_tx stuck low
    auto_a = 1'b0;
    repeat (2) @(negedge clk);
    bs = tx_log_a.size(); bk = ack_log_a.size(); be = err_log_a.size();
    req_a = 4'b0010;
    wait_for(2, 20, "t4_wait_start");
    wait_for(1, 150, "t4_wait_err");
    check_eq("t4_err",      32'(err_log_a[be]), 32'b0010);
    check_eq("t4_err_lat",  32'(err_cyc_a - start_cyc_a), 32'd100);
    check_eq("t4_noack",    32'(ack_log_a.size() - bk), 32'd0);
    check_eq("t4_busy",     32'(busy_a), 32'd0);
    auto_a = 1'b1;
    wait_for(0, 100, "t4_wait_ack");
    req_a = '0;
    check_eq("t4_reack",    32'(ack_log_a[bk]), 32'b0010);
    check_eq("t4_nstart",   32'(tx_log_a.size() - bs), 32'd2);

    // Reset during WAIT_DATA
    auto_a = 1'b0;
    repeat (2) @(negedge clk);
    bk = ack_log_a.size(); be = err_log_a.size();
    req_a = 4'b0100;
    wait_for(2, 20, "t5_wait_start");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_start", 32'(start_a), 32'd0);
    check_eq("t5_busy",  32'(busy_a),  32'd0);
    check_eq("t5_ack",   32'(ack_a),   32'd0);
    req_a = '0;
    @(negedge clk);
    rst = 1'b1;
    auto_a = 1'b1;
    check_eq("t5_nack", 32'(ack_log_a.size() - bk), 32'd0);
    check_eq("t5_nerr", 32'(err_log_a.size() - be), 32'd0);
    data_a = 32'h7700_005A;
    req_a  = 4'b1001;
    wait_for(2, 20, "t5_wait_start2");
    check_eq("t5_gid", 32'(gid_a), 32'd0);
    check_eq("t5_tx",  32'(tx_a),  32'h5A);
    wait_for(0, 100, "t5_wait_ack");
    req_a = '0;
    check_eq("t5_ack0", 32'(ack_log_a[bk]), 32'b0001);

    // Stale done_tx already high before start
    auto_a = 1'b0;
    repeat (2) @(negedge clk);
    done_man_a = 1'b1;
    repeat (2) @(negedge clk);
    bk = ack_log_a.size();
    req_a = 4'b0001;
    wait_for(2, 20, "t6_wait_start");
    repeat (10) @(negedge clk);
    check_eq("t6_noack", 32'(ack_log_a.size() - bk), 32'd0);
    check_eq("t6_busy",  32'(busy_a), 32'd1);
    done_man_a = 1'b0;
    repeat (2) @(negedge clk);
    done_man_a = 1'b1;
    wait_for(0, 10, "t6_wait_ack");
    req_a = '0;
    done_man_a = 1'b0;
    check_eq("t6_ack", 32'(ack_log_a[bk]), 32'b0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter among N requesters using round-robin arbitration.
- Sequences each granted byte onto the UART TX handshake (start / done_tx).
- Optionally prefixes each byte with an ID tag byte.
- Watchdog aborts a transfer whose done_tx never arrives. Sits between client logic and the UART top.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 8, byte width; must match the UART
- TAG_EN, 0, 1 = send tag byte {4'hA, id[3:0]} before each data byte
- TIMEOUT_CYCLES, 32768, max clk cycles from start to done_tx rising edge (one 19200-baud frame at 50 MHz is ~26042)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- req  in  N_REQ  per-requester request, level
- req_data  in  N_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
- ack  out  N_REQ  one-cycle pulse: requester's byte fully sent
- err  out  N_REQ  one-cycle pulse: requester's transfer aborted by timeout
- busy  out  1  high whenever state != IDLE
- grant_id  out  $clog2(N_REQ)  index of the current owner, valid while busy
- start  out  1  one-cycle pulse to UART start
- tx_data_in  out  DATA_WIDTH  byte to UART, held stable from start until the done_tx edge
- done_tx  in  1  UART done; the scheduler acts on its rising edge only
- tx_active  in  1  UART busy; informational, used only for the start gate

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; ack, err, start, busy, grant_id, tx_data_in = 0; last_grant = N_REQ-1, so requester 0 has first priority; timer = 0; done_tx_q = 0.
- Reset mid-transfer aborts with no ack or err. The UART is reset separately.
- States: IDLE, LOAD, START_TAG, WAIT_TAG, START_DATA, WAIT_DATA, DONE.
- IDLE: if req != 0 and tx_active == 0, pick the winner. Search starts at last_grant+1 and wraps modulo N_REQ. On the edge, latch grant_id, the byte (data_q) and last_grant; go to LOAD.
- LOAD: one cycle. Drive tx_data_in = tag when TAG_EN, else data_q. Go to START_TAG if TAG_EN, else START_DATA.
- START_*: start=1 for exactly this cycle; clear timer; go to the matching WAIT_*.
- WAIT_*: timer increments each cycle.
  - On done_tx rising edge (done_tx & ~done_tx_q):
    - WAIT_TAG: tx_data_in = data_q, go to START_DATA.
    - WAIT_DATA: go to DONE.
  - If timer reaches TIMEOUT_CYCLES-1 without an edge: err[grant_id]=1 for one cycle, go to IDLE.
- DONE: ack[grant_id]=1 for one cycle; go to IDLE.
- Latency with TAG_EN=0: req sampled in IDLE at cycle k; start at cycle k+2; ack one cycle after the done_tx rising edge is sampled.
- Requester rules:
  - Hold req and req_data until ack or err.
  - Dropping req after the grant does not cancel the transfer.
  - Requester with req still high after ack re-competes; round-robin prevents starvation.
- Simultaneous requests: lowest index at or above last_grant+1 (with wrap) wins. Example N=4, last_grant=1, req=4'b1011: grant 3, then 0, then 1.
- done_tx already high when a WAIT state is entered is not an edge; the scheduler waits for a fresh rising edge.
- Timer width: $clog2(TIMEOUT_CYCLES)+1; no wrap.
- ack and err are never both set; at most one bit of each vector is high.

Decomposition:
- uart_pkg gains:
  - typedef enum logic [2:0] sched_state_t for the seven states
  - localparam TAG_NIBBLE = 4'hA
  - function tag_byte(id)
- Sub-module uart_rr_pick (combinational): inputs req and last_grant; outputs grant_valid and grant_idx, via a rotate / priority-encode / un-rotate scheme. It is reused by future RX-side clients.

Test Plan:
- Single requester, N_REQ=4, TAG_EN=0: req=4'b0001, req_data[7:0]=8'hA5 -> one start pulse; tx_data_in=8'hA5; ack=4'b0001 once; loopback rx_data_out=8'hA5; busy low afterwards.
- Contention: req=4'b1111 held with bytes 8'h11, 8'h22, 8'h33, 8'h44 -> ack order 0,1,2,3,0; grant_id sequence matches.
- TAG_EN=1, requester 2, byte 8'h3C -> two start pulses: tx_data_in=8'hA2 then 8'h3C; a single ack=4'b0100 after the second done_tx edge.
- Timeout: done_tx stuck at 0, TIMEOUT_CYCLES=100, req=4'b0010 -> err=4'b0010 pulse exactly 100 cycles after start; no ack; state returns to IDLE and re-arbitrates.
- Reset mid-transfer: rst=0 during WAIT_DATA -> next edge start=0, busy=0, ack=0; after release, req=4'b0001 is granted first.
- Stale done_tx: hold done_tx=1 before start -> no ack until done_tx falls and rises again.
